// File: rtl/rf_pkg.sv
// Shared types and constants for the register file and its scoreboard.
// Build option: RF_BYPASS_EN forwards same-cycle write-back to the read ports.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PEND_W   = 2;
    localparam int PEND_MAX = (2 ** PEND_W) - 1;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_pend_ctr.sv
// Saturating up/down counter of in-flight writers for one register.
// Simultaneous inc and dec cancel; dec at zero and inc at max are held.
module rf_pend_ctr
    import rf_pkg::*;
#(
    parameter int PEND_W = rf_pkg::PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt
);

    localparam logic [PEND_W-1:0] W_MAX = '1;

    logic [PEND_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && !dec && r_cnt != W_MAX) begin
            r_cnt <= r_cnt + PEND_W'(1);
        end else if (dec && !inc && r_cnt != '0) begin
            r_cnt <= r_cnt - PEND_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/reg_file.sv
// 16x32 architectural register file with per-register pending-write scoreboard.
// Build option: RF_BYPASS_EN forwards same-cycle write-back to the read ports.
module reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int PEND_W = rf_pkg::PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic              issue_wb,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              issue_ready
);

    localparam int NUM_R = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] W_MAX = '1;

    logic [DATA_W-1:0] r_regs [NUM_R];
    logic [PEND_W-1:0] w_pend [NUM_R];
    logic              w_issue_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_R; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wen) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    assign issue_ready = !(issue_wb && w_pend[issue_dst] == W_MAX);
    assign w_issue_acc = issue_valid && issue_wb && issue_ready;

    for (genvar g = 0; g < NUM_R; g++) begin : g_pend
        rf_pend_ctr #(
            .PEND_W(PEND_W)
        ) u_ctr (
            .clk(clk),
            .rst(rst),
            .inc(w_issue_acc && issue_dst == ADDR_W'(g)),
            .dec(wen && wb_addr == ADDR_W'(g)),
            .cnt(w_pend[g])
        );
    end

`ifdef RF_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = wen && wb_addr == rs1_addr;
    assign w_rs2_hit = wen && wb_addr == rs2_addr;

    assign rs1_data = w_rs1_hit ? wb_data : r_regs[rs1_addr];
    assign rs2_data = w_rs2_hit ? wb_data : r_regs[rs2_addr];

    // Last outstanding writer retiring now: decode may issue this cycle.
    assign rs1_busy = w_pend[rs1_addr] != '0 &&
                      !(w_rs1_hit && w_pend[rs1_addr] == PEND_W'(1));
    assign rs2_busy = w_pend[rs2_addr] != '0 &&
                      !(w_rs2_hit && w_pend[rs2_addr] == PEND_W'(1));
`else
    assign rs1_data = r_regs[rs1_addr];
    assign rs2_data = r_regs[rs2_addr];
    assign rs1_busy = w_pend[rs1_addr] != '0;
    assign rs2_busy = w_pend[rs2_addr] != '0;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus random model run.
module tb_reg_file;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_valid;
    logic        issue_wb;
    logic [3:0]  issue_dst;
    logic        issue_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk),
        .rst(rst),
        .wen(wen),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .issue_valid(issue_valid),
        .issue_wb(issue_wb),
        .issue_dst(issue_dst),
        .issue_ready(issue_ready)
    );

    typedef struct {
        logic        rst;
        logic        wen;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic        iv;
        logic        iwb;
        logic [3:0]  dst;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        b1;
        logic        b2;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic r, logic w, logic [3:0] wa, logic [31:0] wd,
        logic [3:0] a1, logic [3:0] a2,
        logic iv, logic iwb, logic [3:0] dst,
        logic [31:0] e1, logic [31:0] e2,
        logic b1, logic b2, logic rdy);
        vec_t v;
        v.rst = r;  v.wen = w;  v.wa = wa;  v.wd = wd;
        v.a1 = a1;  v.a2 = a2;
        v.iv = iv;  v.iwb = iwb;  v.dst = dst;
        v.e1 = e1;  v.e2 = e2;
        v.b1 = b1;  v.b2 = b2;  v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst;  wen = v.wen;  wb_addr = v.wa;  wb_data = v.wd;
        rs1_addr = v.a1;  rs2_addr = v.a2;
        issue_valid = v.iv;  issue_wb = v.iwb;  issue_dst = v.dst;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: plain arrays of values and writer counts.
    logic [31:0] m_reg  [16];
    int          m_pend [16];

    function automatic logic [31:0] m_rd(logic [3:0] a);
        if (BYP && wen && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic m_busy(logic [3:0] a);
        if (m_pend[a] == 0) return 1'b0;
        if (BYP && wen && wb_addr == a && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_ready();
        return !(issue_wb && m_pend[issue_dst] == 3);
    endfunction

    task automatic m_update();
        logic acc;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] = '0;
                m_pend[i] = 0;
            end
        end else begin
            acc = issue_valid && issue_wb && m_ready();
            if (wen) m_reg[wb_addr] = wb_data;
            for (int i = 0; i < 16; i++) begin
                if (acc && issue_dst == 4'(i) && !(wen && wb_addr == 4'(i)))
                    m_pend[i] = m_pend[i] + 1;
                else if (wen && wb_addr == 4'(i) &&
                         !(acc && issue_dst == 4'(i)) && m_pend[i] > 0)
                    m_pend[i] = m_pend[i] - 1;
            end
        end
    endtask

    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        vec_t v;
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(v);
        tick();
        tick();
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            rs1_addr = 4'(a);
            rs2_addr = 4'(15 - a);
            issue_wb = 1'b1;
            issue_dst = 4'(a);
            #1;
            chk("reset_rs1_data", a, rs1_data, 0);
            chk("reset_rs2_data", a, rs2_data, 0);
            chk("reset_busy", a, {rs1_busy, rs2_busy}, 0);
            chk("reset_ready", a, issue_ready, 1);
            tick();
        end

        tbl.push_back(mk(0,1,5,DB,5,5,0,0,0, BYP?DB:0, BYP?DB:0, 0,0,1));
        tbl.push_back(mk(0,0,0,0,5,5,0,0,0, DB,DB,0,0,1));
        tbl.push_back(mk(0,0,0,0,3,5,1,1,3, 0,DB,0,0,1));
        tbl.push_back(mk(0,0,0,0,3,5,1,1,3, 0,DB,1,0,1));
        tbl.push_back(mk(0,1,3,32'h33,3,3,0,0,0, BYP?32'h33:0, BYP?32'h33:0, 1,1,1));
        tbl.push_back(mk(0,1,3,32'h44,3,3,0,0,0, BYP?32'h44:32'h33,
                         BYP?32'h44:32'h33, !BYP,!BYP,1));
        tbl.push_back(mk(0,0,0,0,3,3,0,0,0, 32'h44,32'h44,0,0,1));
        tbl.push_back(mk(0,0,0,0,7,8,1,1,7, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,7,8,1,1,7, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,7,8,1,1,7, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,7,8,1,1,7, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,7,8,0,1,8, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,7,8,0,0,7, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,8,7,1,1,8, 0,0,0,1,1));
        tbl.push_back(mk(0,1,7,32'h70,7,8,0,0,0, BYP?32'h70:0, 0, 1,1,1));
        tbl.push_back(mk(0,1,7,32'h71,7,8,0,0,0, BYP?32'h71:32'h70, 0, 1,1,1));
        tbl.push_back(mk(0,1,7,32'h72,7,7,0,0,0, BYP?32'h72:32'h71,
                         BYP?32'h72:32'h71, !BYP,!BYP,1));
        tbl.push_back(mk(0,0,0,0,7,8,0,1,7, 32'h72,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,9,9,1,1,9, 0,0,0,0,1));
        tbl.push_back(mk(0,1,9,32'h99,9,9,1,1,9, BYP?32'h99:0, BYP?32'h99:0,
                         !BYP,!BYP,1));
        tbl.push_back(mk(0,0,0,0,9,9,0,0,0, 32'h99,32'h99,1,1,1));
        tbl.push_back(mk(0,1,10,32'hAA,10,9,0,0,0, BYP?32'hAA:0, 32'h99, 0,1,1));
        tbl.push_back(mk(0,0,0,0,10,10,0,1,10, 32'hAA,32'hAA,0,0,1));
        tbl.push_back(mk(0,1,2,32'h1234,2,5,0,0,0, BYP?32'h1234:0, DB, 0,0,1));
        tbl.push_back(mk(0,0,0,0,2,5,1,1,2, 32'h1234,DB,0,0,1));
        tbl.push_back(mk(0,0,0,0,2,5,1,1,2, 32'h1234,DB,1,0,1));
        tbl.push_back(mk(1,1,2,32'h5678,2,2,1,1,2, BYP?32'h5678:32'h1234,
                         BYP?32'h5678:32'h1234, 1,1,1));
        tbl.push_back(mk(0,0,0,0,2,5,0,1,2, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,3,9,0,1,9, 0,0,0,0,1));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk("vec_rs1_data", i, rs1_data, tbl[i].e1);
            chk("vec_rs2_data", i, rs2_data, tbl[i].e2);
            chk("vec_rs1_busy", i, rs1_busy, tbl[i].b1);
            chk("vec_rs2_busy", i, rs2_busy, tbl[i].b2);
            chk("vec_ready", i, issue_ready, tbl[i].rdy);
            tick();
        end

        rst = 1'b1;
        wen = 1'b0;
        issue_valid = 1'b0;
        m_update();
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            wen = $urandom_range(0, 1) == 1;
            wb_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 3));
            wb_data = $urandom;
            rs1_addr = 4'($urandom_range(0, 4));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr
                                                  : 4'($urandom_range(0, 15));
            issue_valid = $urandom_range(0, 3) != 0;
            issue_wb = $urandom_range(0, 4) != 0;
            issue_dst = 4'($urandom_range(0, 3));
            #1;
            chk("rnd_rs1_data", n, rs1_data, m_rd(rs1_addr));
            chk("rnd_rs2_data", n, rs2_data, m_rd(rs2_addr));
            chk("rnd_rs1_busy", n, rs1_busy, m_busy(rs1_addr));
            chk("rnd_rs2_busy", n, rs2_busy, m_busy(rs2_addr));
            chk("rnd_ready", n, issue_ready, m_ready());
            @(posedge clk);
            m_update();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
